cpu_run_ctrl: RTL and testbench

- Execution controller directly upstream of the single-cycle CPU top.
- Generates the CPU's `en` (cpu_en) for free-run at full or divided rate, or for single-step.
- Consumes the CPU's halt/is_jump/is_branch/branched outputs to stop execution and keep retirement statistics for the board display.

---
 rtl/cpu_run_ctrl_pkg.sv | 15 +
 rtl/cpu_run_ctrl_syn_stat_counter.sv | 31 +++
 rtl/cpu_run_ctrl.sv | 111 +++++++++++
 tb/tb_cpu_run_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the CPU execution controller.
//   RC_STATE_BIT : width of the controller state output
//   rc_state_e   : controller states (IDLE=0, RUN=1, STEP=2, HALTED=3)
package cpu_run_ctrl_pkg;

  localparam int unsigned RC_STATE_BIT = 2;

  typedef enum logic [RC_STATE_BIT-1:0] {
    RC_STATE_IDLE   = 2'd0,
    RC_STATE_RUN    = 2'd1,
    RC_STATE_STEP   = 2'd2,
    RC_STATE_HALTED = 2'd3
  } rc_state_e;

endpackage

// File: rtl/cpu_run_ctrl_syn_stat_counter.sv
// Wrapping statistics counter with synchronous reset and clear.
//   clk : clock
//   rst : synchronous active-high reset (highest priority)
//   clr : synchronous clear (overrides inc)
//   inc : increment by one this cycle
//   cnt : current count, wraps modulo 2^W
module syn_stat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Execution controller in front of the single-cycle CPU.
// Produces the CPU enable for free-run (full or divided rate) and
// single-step, stops on CPU halt, and counts retired instructions.
//   clk, rst   : clock, synchronous active-high reset
//   run_req    : level, free-run request
//   step_req   : level, each rising edge requests one instruction
//   speed_sel  : 0 = full rate, 1 = one enable per 2^SLOW_SHIFT RUN cycles
//   clr_stats  : synchronous clear of the statistics counters
//   halt, is_jump, is_branch, branched : CPU status for this cycle
//   cpu_en     : CPU enable, one instruction retires per high cycle
//   state      : controller state (see rc_state_e)
//   inst_cnt, jump_cnt, branch_cnt, taken_cnt : retirement statistics
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned SLOW_SHIFT = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run_req,
  input  logic                    step_req,
  input  logic                    speed_sel,
  input  logic                    clr_stats,
  input  logic                    halt,
  input  logic                    is_jump,
  input  logic                    is_branch,
  input  logic                    branched,
  output logic                    cpu_en,
  output logic [RC_STATE_BIT-1:0] state,
  output logic [CNT_WIDTH-1:0]    inst_cnt,
  output logic [CNT_WIDTH-1:0]    jump_cnt,
  output logic [CNT_WIDTH-1:0]    branch_cnt,
  output logic [CNT_WIDTH-1:0]    taken_cnt
);

  rc_state_e             state_q, state_d;
  logic [SLOW_SHIFT-1:0] div_cnt_q, div_cnt_d;
  logic                  step_q;
  logic                  step_edge;
  logic                  tick;

  assign step_edge = step_req & ~step_q;
  assign tick      = ~speed_sel | (&div_cnt_q);

  // cpu_en stays combinational so halt blocks retirement in the same cycle.
  assign cpu_en = ~halt & (((state_q == RC_STATE_RUN) & tick) |
                           (state_q == RC_STATE_STEP));

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    if (halt) begin
      state_d = RC_STATE_HALTED;
    end else begin
      unique case (state_q)
        RC_STATE_IDLE: begin
          if (run_req) begin
            state_d   = RC_STATE_RUN;
            div_cnt_d = '0;
          end else if (step_edge) begin
            state_d = RC_STATE_STEP;
          end
        end
        RC_STATE_RUN: begin
          if (!run_req) state_d = RC_STATE_IDLE;
        end
        RC_STATE_STEP:   state_d = RC_STATE_IDLE;
        RC_STATE_HALTED: state_d = RC_STATE_IDLE;
        default:         state_d = RC_STATE_IDLE;
      endcase
    end
    // Divider advances in every RUN cycle, including the one that leaves RUN.
    if (state_q == RC_STATE_RUN) div_cnt_d = div_cnt_q + SLOW_SHIFT'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RC_STATE_IDLE;
      div_cnt_q <= '0;
      step_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      step_q    <= step_req;
    end
  end

  assign state = state_q;

  syn_stat_counter #(.W(CNT_WIDTH)) u_inst_cnt (
    .clk (clk), .rst (rst), .clr (clr_stats),
    .inc (cpu_en), .cnt (inst_cnt)
  );

  syn_stat_counter #(.W(CNT_WIDTH)) u_jump_cnt (
    .clk (clk), .rst (rst), .clr (clr_stats),
    .inc (cpu_en & is_jump), .cnt (jump_cnt)
  );

  syn_stat_counter #(.W(CNT_WIDTH)) u_branch_cnt (
    .clk (clk), .rst (rst), .clr (clr_stats),
    .inc (cpu_en & is_branch), .cnt (branch_cnt)
  );

  syn_stat_counter #(.W(CNT_WIDTH)) u_taken_cnt (
    .clk (clk), .rst (rst), .clr (clr_stats),
    .inc (cpu_en & is_branch & branched), .cnt (taken_cnt)
  );

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl with 4-bit counters and an 8-cycle slow period.
module tb_cpu_run_ctrl;

  localparam int unsigned CW  = 4;
  localparam int unsigned SS  = 3;
  localparam int          PER = 1 << SS;
  localparam int          MOD = 1 << CW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, run_req, step_req, speed_sel, clr_stats;
  logic          halt, is_jump, is_branch, branched;
  logic          cpu_en;
  logic [1:0]    state;
  logic [CW-1:0] inst_cnt, jump_cnt, branch_cnt, taken_cnt;

  cpu_run_ctrl #(.CNT_WIDTH(CW), .SLOW_SHIFT(SS)) dut (
    .clk        (clk),
    .rst        (rst),
    .run_req    (run_req),
    .step_req   (step_req),
    .speed_sel  (speed_sel),
    .clr_stats  (clr_stats),
    .halt       (halt),
    .is_jump    (is_jump),
    .is_branch  (is_branch),
    .branched   (branched),
    .cpu_en     (cpu_en),
    .state      (state),
    .inst_cnt   (inst_cnt),
    .jump_cnt   (jump_cnt),
    .branch_cnt (branch_cnt),
    .taken_cnt  (taken_cnt)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic rst, run, step, spd, clr, halt, j, b, bt;
    logic       exp_en;
    logic [1:0] exp_st;
    logic [3:0] exp_inst;
  } vec_t;

  // Reference model: states as plain ints, run_len = RUN cycles already
  // completed since entering RUN, counters as unbounded ints reduced mod 2^CW.
  int m_st, m_run_len, m_inst, m_jump, m_br, m_tk;
  bit m_step_prev;

  logic          last_en;
  logic [CW-1:0] last_inst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic run, input logic st,
                              input logic spd, input logic clr, input logic h,
                              input logic j, input logic b, input logic bt,
                              input logic e, input logic [1:0] es, input logic [3:0] ei);
    vec_t v;
    v.rst = r; v.run = run; v.step = st; v.spd = spd; v.clr = clr; v.halt = h;
    v.j = j; v.b = b; v.bt = bt; v.exp_en = e; v.exp_st = es; v.exp_inst = ei;
    return v;
  endfunction

  task automatic cyc(input vec_t v, input bit chk_model, input bit chk_vec);
    bit m_tick, m_en;
    @(negedge clk);
    rst = v.rst; run_req = v.run; step_req = v.step; speed_sel = v.spd;
    clr_stats = v.clr; halt = v.halt; is_jump = v.j; is_branch = v.b; branched = v.bt;
    #1;
    last_en   = cpu_en;
    last_inst = inst_cnt;
    m_tick = (v.spd == 1'b0) || ((m_run_len % PER) == PER - 1);
    m_en   = !v.halt && ((m_st == 1 && m_tick) || m_st == 2);
    if (chk_model) begin
      chk("model_cpu_en", {31'd0, cpu_en}, {31'd0, m_en});
      chk("model_state",  {30'd0, state}, m_st);
      chk("model_inst",   {28'd0, inst_cnt},   m_inst % MOD);
      chk("model_jump",   {28'd0, jump_cnt},   m_jump % MOD);
      chk("model_branch", {28'd0, branch_cnt}, m_br % MOD);
      chk("model_taken",  {28'd0, taken_cnt},  m_tk % MOD);
    end
    if (chk_vec) begin
      chk("vec_cpu_en", {31'd0, cpu_en}, {31'd0, v.exp_en});
      chk("vec_state",  {30'd0, state},  {30'd0, v.exp_st});
      chk("vec_inst",   {28'd0, inst_cnt}, {28'd0, v.exp_inst});
    end
    // advance the model across the coming clock edge
    if (v.rst) begin
      m_st = 0; m_run_len = 0; m_step_prev = 0;
      m_inst = 0; m_jump = 0; m_br = 0; m_tk = 0;
    end else begin
      if (v.clr) begin
        m_inst = 0; m_jump = 0; m_br = 0; m_tk = 0;
      end else if (m_en) begin
        m_inst++; m_jump += v.j; m_br += v.b; m_tk += (v.b & v.bt);
      end
      if (m_st == 1) m_run_len++;
      if (v.halt) m_st = 3;
      else if (m_st == 0) begin
        if (v.run) begin m_st = 1; m_run_len = 0; end
        else if (v.step && !m_step_prev) m_st = 2;
      end else if (m_st == 1) begin
        if (!v.run) m_st = 0;
      end else m_st = 0;
      m_step_prev = v.step;
    end
  endtask

  vec_t tbl[$];
  vec_t z;

  initial begin
    rst = 1; run_req = 0; step_req = 0; speed_sel = 0; clr_stats = 0;
    halt = 0; is_jump = 0; is_branch = 0; branched = 0;
    m_st = 0; m_run_len = 0; m_step_prev = 0;
    m_inst = 0; m_jump = 0; m_br = 0; m_tk = 0;
    z = mk(0,0,0,0,0,0,0,0,0, 0,0,0);

    //                 rst run stp spd clr hlt j b bt   en st inst
    tbl.push_back(mk(1, 0,  0,  0,  0,  0,  0,0,0,  0, 0, 0)); // reset
    tbl.push_back(mk(0, 0,  0,  0,  0,  0,  0,0,0,  0, 0, 0));
    tbl.push_back(mk(0, 0,  1,  0,  0,  0,  0,1,1,  0, 0, 0)); // step edge
    tbl.push_back(mk(0, 0,  1,  0,  0,  0,  0,1,1,  1, 2, 0)); // STEP retires
    tbl.push_back(mk(0, 0,  1,  0,  0,  0,  0,0,0,  0, 0, 1)); // back to IDLE
    tbl.push_back(mk(0, 0,  1,  0,  0,  0,  0,0,0,  0, 0, 1)); // held: no 2nd step
    tbl.push_back(mk(0, 0,  1,  0,  0,  0,  0,0,0,  0, 0, 1));
    tbl.push_back(mk(0, 0,  0,  0,  0,  0,  0,0,0,  0, 0, 1));
    tbl.push_back(mk(0, 1,  0,  0,  0,  0,  1,0,0,  0, 0, 1)); // IDLE->RUN
    tbl.push_back(mk(0, 1,  0,  0,  0,  0,  1,0,0,  1, 1, 1));
    tbl.push_back(mk(0, 1,  0,  0,  0,  0,  0,0,0,  1, 1, 2));
    tbl.push_back(mk(0, 0,  0,  0,  0,  0,  0,0,0,  1, 1, 3)); // last RUN cycle retires
    tbl.push_back(mk(0, 0,  0,  0,  0,  0,  0,0,0,  0, 0, 4));
    tbl.push_back(mk(0, 0,  0,  0,  1,  0,  0,0,0,  0, 0, 4)); // clear
    tbl.push_back(mk(0, 0,  0,  0,  0,  0,  0,0,0,  0, 0, 0));
    tbl.push_back(mk(0, 1,  0,  0,  0,  0,  0,0,0,  0, 0, 0));
    tbl.push_back(mk(0, 1,  0,  0,  0,  1,  0,0,0,  0, 1, 0)); // halt in RUN
    tbl.push_back(mk(0, 0,  1,  0,  0,  1,  0,0,0,  0, 3, 0)); // step ignored
    tbl.push_back(mk(0, 0,  0,  0,  0,  1,  0,0,0,  0, 3, 0));
    tbl.push_back(mk(0, 0,  0,  0,  0,  0,  0,0,0,  0, 3, 0)); // halt drops
    tbl.push_back(mk(0, 0,  0,  0,  0,  0,  0,0,0,  0, 0, 0));
    tbl.push_back(mk(0, 1,  0,  0,  0,  0,  0,0,0,  0, 0, 0));
    tbl.push_back(mk(0, 1,  0,  0,  1,  0,  0,0,0,  1, 1, 0)); // clr beats inc
    tbl.push_back(mk(0, 0,  0,  0,  0,  0,  0,0,0,  1, 1, 0));
    tbl.push_back(mk(0, 0,  0,  0,  0,  0,  0,0,0,  0, 0, 1));

    cyc(mk(1,0,0,0,0,0,0,0,0, 0,0,0), 0, 0);
    foreach (tbl[i]) cyc(tbl[i], 1, 1);

    // full-rate run of 10 jumps
    cyc(mk(0,0,0,0,1,0,0,0,0, 0,0,0), 1, 0);
    cyc(mk(0,1,0,0,0,0,1,0,0, 0,0,0), 1, 0);
    for (int k = 1; k <= 10; k++) begin
      cyc(mk(0, (k < 10), 0,0,0,0,1,0,0, 0,0,0), 1, 0);
      chk("full_en", {31'd0, last_en}, 32'd1);
    end
    cyc(z, 1, 0);
    chk("full_inst", {28'd0, inst_cnt}, 32'd10);
    chk("full_jump", {28'd0, jump_cnt}, 32'd10);

    // slow run: pulses only in RUN cycles 8,16,24,32
    cyc(mk(0,0,0,1,1,0,0,0,0, 0,0,0), 1, 0);
    cyc(mk(0,1,0,1,0,0,0,0,0, 0,0,0), 1, 0);
    for (int k = 1; k <= 32; k++) begin
      cyc(mk(0, (k < 32), 0,1,0,0,0,0,0, 0,0,0), 1, 0);
      chk("slow_en", {31'd0, last_en}, {31'd0, (k % PER) == 0});
    end
    cyc(z, 1, 0);
    chk("slow_inst", {28'd0, inst_cnt}, 32'd4);

    // 17 retirements wrap the 4-bit counter to 1
    cyc(mk(0,0,0,0,1,0,0,0,0, 0,0,0), 1, 0);
    cyc(mk(0,1,0,0,0,0,0,0,0, 0,0,0), 1, 0);
    for (int k = 1; k <= 17; k++) cyc(mk(0, (k < 17), 0,0,0,0,0,0,0, 0,0,0), 1, 0);
    cyc(z, 1, 0);
    chk("wrap_inst", {28'd0, inst_cnt}, 32'd1);

    // reset held 3 cycles during RUN, run_req kept high
    cyc(mk(0,1,0,0,0,0,0,0,0, 0,0,0), 1, 0);
    cyc(mk(0,1,0,0,0,0,0,0,0, 0,0,0), 1, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(mk(1,1,0,0,0,0,0,0,0, 0,0,0), 1, 0);
      if (k > 0) chk("rst_no_en", {31'd0, last_en}, 32'd0);
    end
    cyc(mk(0,1,0,0,0,0,0,0,0, 0,0,0), 1, 0);
    chk("rst_state_idle", {30'd0, state}, 32'd0);
    chk("rst_inst", {28'd0, inst_cnt}, 32'd0);
    cyc(mk(0,0,0,0,0,0,0,0,0, 0,0,0), 1, 0);
    chk("rst_rerun", {30'd0, state}, 32'd1);

    // randomized traffic against the model
    begin
      vec_t v;
      v = z;
      for (int n = 0; n < 800; n++) begin
        v.rst  = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 9) == 0) v.run = ~v.run;
        if ($urandom_range(0, 19) == 0) v.spd = ~v.spd;
        v.step = ($urandom_range(0, 2) == 0);
        v.clr  = ($urandom_range(0, 24) == 0);
        v.halt = ($urandom_range(0, 14) == 0);
        v.j    = 1'($urandom);
        v.b    = 1'($urandom);
        v.bt   = 1'($urandom);
        cyc(v, 1, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
